// File: rtl/button_event_decoder.sv
// Classifies the debounced button level into one-cycle UI event pulses (press/release, short, long,
// double click). Optional auto-repeat while held past a long press is enabled by BTN_AUTO_REPEAT_EN.
module button_event_decoder #(
    parameter int LONG_CNT   = 50,
    parameter int DCLICK_CNT = 20,
    parameter int REPEAT_CNT = 10,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic db_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic held
);

    // state     | meaning
    // IDLE      | button released, no event pending
    // PRESSED   | first press, timing toward long press
    // LONG_HELD | long press reported, waiting for release (auto-repeat here)
    // WAIT_2ND  | short release seen, window open for a second press
    // PRESSED2  | second press of a double click, waiting for release
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        PRESSED2  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    if (LONG_CNT < 2 || DCLICK_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_param
        $error("button_event_decoder: timing parameters must be >= 2");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             db_q;
    logic             short_n, long_n, dclick_n, repeat_n, held_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            db_q          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            db_q          <= db_in;
            press_pulse   <= db_in & ~db_q;
            release_pulse <= ~db_in & db_q;
            short_press   <= short_n;
            long_press    <= long_n;
            double_click  <= dclick_n;
            repeat_pulse  <= repeat_n;
            held          <= held_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        short_n  = 1'b0;
        long_n   = 1'b0;
        dclick_n = 1'b0;
        repeat_n = 1'b0;
        case (state)
            IDLE: begin
                if (db_in) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end
            end
            PRESSED: begin
                // release is checked first so a release on the long-press edge is still short
                if (!db_in) begin
                    state_n = WAIT_2ND;
                    cnt_n   = '0;
                end else if (cnt == LONG_LAST) begin
                    long_n  = 1'b1;
                    state_n = LONG_HELD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!db_in) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (cnt == REPEAT_LAST) begin
                        repeat_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
`else
                    cnt_n = (cnt == REPEAT_LAST) ? cnt : '0;
`endif
                end
            end
            WAIT_2ND: begin
                if (db_in) begin
                    dclick_n = 1'b1;
                    state_n  = PRESSED2;
                    cnt_n    = '0;
                end else if (cnt == DCLICK_LAST) begin
                    short_n = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED2: begin
                if (!db_in) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        held_n = (state_n == PRESSED) || (state_n == LONG_HELD) || (state_n == PRESSED2);
    end

endmodule
